// File: rtl/cone_eval_scheduler_pkg.sv
// Shared types and sizing helpers for the cone evaluation scheduler.
package cone_eval_scheduler_pkg;

    localparam int unsigned OPERAND_W = 2;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StResp
    } state_e;

    // Width of the settle counter; it must be able to hold SETTLE_CYCLES.
    function automatic int unsigned cnt_width(input int unsigned settle_cycles);
        return $clog2(settle_cycles + 1);
    endfunction

endpackage

// File: rtl/cone_rr_arb.sv
// Round-robin arbiter: the requester at index ptr has top priority, then ptr+1, and so on.
module cone_rr_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    // Walk from the lowest priority up so the highest-priority hit is written last.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = IDX_W'((int'(ptr) + off) % int'(NUM_REQ));
            if (req[cand]) begin
                gnt = NUM_REQ'(1) << cand;
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cone_eval_scheduler.sv
// Time-multiplexes one shared NOR cone among NUM_REQ requesters: grant, settle, sample, respond.
module cone_eval_scheduler
    import cone_eval_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [OPERAND_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           cone_a,
    output logic                           cone_b,
    input  logic                           cone_y,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic                           rsp_data,
    output logic                           busy,
    output logic                           err_sticky
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       id_q;
    logic                   a_q, b_q, y_q, err_q;

    logic [NUM_REQ-1:0]     gnt;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   gnt_any;
    logic [OPERAND_W-1:0]   gnt_op;
    logic                   grant_en;
    logic                   sample_en;

    cone_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign gnt_op = req_data[OPERAND_W*gnt_idx +: OPERAND_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        grant_en  = 1'b0;
        sample_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gnt_any) begin
                    grant_en = 1'b1;
                    state_d  = StSettle;
                    cnt_d    = '0;
                    ptr_d    = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
            StSettle: begin
                if (cnt_q == CntLast) begin
                    sample_en = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            y_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            if (grant_en) begin
                id_q <= gnt_idx;
                a_q  <= gnt_op[0];
                b_q  <= gnt_op[1];
            end
            if (sample_en) begin
                y_q <= cone_y;
                if (cone_y != ~(a_q | b_q)) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Outputs are gated by rst so they read zero for the whole reset window, including its first cycle.
    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_data   = 1'b0;
        cone_a     = 1'b0;
        cone_b     = 1'b0;
        busy       = 1'b0;
        err_sticky = 1'b0;
        if (!rst) begin
            if (state_q == StIdle) begin
                req_ready = gnt;
            end
            if (state_q == StResp) begin
                rsp_valid = NUM_REQ'(1) << id_q;
                rsp_data  = y_q;
            end
            cone_a     = a_q;
            cone_b     = b_q;
            busy       = (state_q != StIdle);
            err_sticky = err_q;
        end
    end

endmodule

// File: tb/tb_cone_eval_scheduler.sv
// Directed bench for cone_eval_scheduler with a per-cycle transaction-level reference model.
module tb_cone_eval_scheduler;

    localparam int N = 4;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_valid = '0;
    logic [7:0] req_data = '0;
    logic       force_bad = 1'b0;
    logic [3:0] req_ready, rsp_valid;
    logic       cone_a, cone_b, cone_y, rsp_data, busy, err_sticky;

    logic [3:0] sw_valid = '0;
    logic [7:0] sw_data = '0;
    logic [3:0] s1_ready, s1_rsp, s5_ready, s5_rsp;
    logic       s1_a, s1_b, s1_rd, s1_busy, s1_err;
    logic       s5_a, s5_b, s5_rd, s5_busy, s5_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    assign cone_y = force_bad | ~(cone_a | cone_b);

    cone_eval_scheduler #(.NUM_REQ(N), .SETTLE_CYCLES(S)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .cone_a(cone_a), .cone_b(cone_b), .cone_y(cone_y),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .err_sticky(err_sticky)
    );

    cone_eval_scheduler #(.NUM_REQ(N), .SETTLE_CYCLES(1)) u_s1 (
        .clk(clk), .rst(rst), .req_valid(sw_valid), .req_data(sw_data),
        .req_ready(s1_ready), .cone_a(s1_a), .cone_b(s1_b), .cone_y(~(s1_a | s1_b)),
        .rsp_valid(s1_rsp), .rsp_data(s1_rd), .busy(s1_busy), .err_sticky(s1_err)
    );

    cone_eval_scheduler #(.NUM_REQ(N), .SETTLE_CYCLES(5)) u_s5 (
        .clk(clk), .rst(rst), .req_valid(sw_valid), .req_data(sw_data),
        .req_ready(s5_ready), .cone_a(s5_a), .cone_b(s5_b), .cone_y(~(s5_a | s5_b)),
        .rsp_valid(s5_rsp), .rsp_data(s5_rd), .busy(s5_busy), .err_sticky(s5_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Round-robin pick: first valid index strictly after the previous winner.
    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int off = 1; off <= N; off++) begin
            if (v[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    // Reference model: a transaction occupies cycles grant..grant+S+1, response in the last one.
    bit m_active = 0;
    int m_gcyc = 0;
    int m_id = 0;
    int m_last = N - 1;
    bit m_a = 0, m_b = 0, m_samp = 0, m_err = 0;

    always @(negedge clk) begin : model
        int k;
        int p;
        logic [3:0] e_ready, e_rsp;
        logic e_rd, e_busy;
        k = cyc - m_gcyc;
        p = rr_pick(req_valid, m_last);
        e_ready = '0; e_rsp = '0; e_rd = 1'b0; e_busy = 1'b0;
        if (!rst) begin
            if (m_active) begin
                e_busy = 1'b1;
                if (k == S + 1) begin
                    e_rsp = 4'b1 << m_id;
                    e_rd  = m_samp;
                end
            end else if (p >= 0) begin
                e_ready = 4'b1 << p;
            end
        end
        chk("m_req_ready", 32'(req_ready), 32'(e_ready));
        chk("m_rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        chk("m_rsp_data", 32'(rsp_data), 32'(e_rd));
        chk("m_busy", 32'(busy), 32'(e_busy));
        chk("m_err_sticky", 32'(err_sticky), 32'(rst ? 1'b0 : m_err));
        if (rst) begin
            chk("m_cone_rst", 32'({cone_a, cone_b}), 32'd0);
        end else if (m_active) begin
            chk("m_cone_ab", 32'({cone_b, cone_a}), 32'({m_b, m_a}));
        end
        if (rst) begin
            m_active = 0; m_last = N - 1; m_err = 0; m_a = 0; m_b = 0;
        end else if (m_active) begin
            if (k == S) begin
                m_samp = cone_y;
                if (cone_y !== ~(m_a | m_b)) m_err = 1;
            end
            if (k == S + 1) m_active = 0;
        end else if (p >= 0) begin
            m_active = 1; m_gcyc = cyc; m_id = p; m_last = p;
            m_a = req_data[2*p]; m_b = req_data[2*p+1];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(output int idx, output int at);
        idx = -1;
        at = -1;
        for (int n = 0; n < 30; n++) begin
            #2;
            if (|req_ready) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
                at = cyc;
                tick();
                return;
            end
            tick();
        end
        chk("grant_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 30; n++) begin
            #2;
            if (!busy) begin
                tick();
                return;
            end
            tick();
        end
        chk("idle_timeout", 32'd1, 32'd0);
    endtask

    int g, t, t_rel, lat1, lat5;
    int gidx[8];
    int gat[8];
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        tick();
        tick();
        rst = 1'b0;

        // Single request to index 2, operands 00.
        req_valid = 4'b0100;
        req_data = 8'b0000_0000;
        #2;
        chk("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        #2;
        chk("single_cone", 32'({cone_a, cone_b, busy}), 32'b001);
        tick();
        tick();
        #2;
        chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("single_rsp_data", 32'(rsp_data), 32'd1);
        chk("single_err", 32'(err_sticky), 32'd0);
        tick();
        #2;
        chk("single_idle", 32'(busy), 32'd0);
        tick();

        // Fairness with all four requesting.
        do_reset();
        req_data = 8'b11_00_10_01;
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) wait_grant(gidx[i], gat[i]);
        req_valid = '0;
        for (int i = 0; i < 5; i++) chk($sformatf("fair_order%0d", i), 32'(gidx[i]), 32'(exp_order[i]));
        for (int i = 0; i < 4; i++) chk($sformatf("fair_gap%0d", i), 32'(gat[i+1] - gat[i]), 32'd4);
        wait_idle();

        // Wrap after last grant 3.
        req_valid = 4'b0010;
        wait_grant(g, t);
        req_valid = '0;
        chk("wrap_first", 32'(g), 32'd1);
        wait_idle();
        req_valid = 4'b0101;
        wait_grant(g, t);
        req_valid = '0;
        chk("wrap_second", 32'(g), 32'd2);
        wait_idle();

        // Sticky error from a wrong cone result.
        req_valid = 4'b0001;
        req_data = 8'b0000_0011;
        force_bad = 1'b1;
        wait_grant(g, t);
        req_valid = '0;
        chk("err_grant", 32'(g), 32'd0);
        tick();
        #2;
        chk("err_before_sample", 32'(err_sticky), 32'd0);
        tick();
        #2;
        chk("err_after_sample", 32'(err_sticky), 32'd1);
        chk("err_rsp", 32'({rsp_valid, rsp_data}), 32'b0001_1);
        force_bad = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            wait_idle();
            req_valid = 4'b1 << (i % 4);
            req_data = 8'($urandom);
            wait_grant(g, t);
            req_valid = '0;
            chk("clean_grant", 32'(g), 32'(i % 4));
        end
        wait_idle();
        chk("err_still_set", 32'(err_sticky), 32'd1);

        // Reset in the middle of SETTLE.
        req_valid = 4'b0100;
        wait_grant(g, t);
        req_valid = '0;
        tick();
        rst = 1'b1;
        #2;
        chk("midrst_outputs", 32'({req_ready, rsp_valid, rsp_data, cone_a, cone_b, busy, err_sticky}),
            32'd0);
        tick();
        #2;
        chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        rst = 1'b0;
        req_valid = 4'b0011;
        t_rel = cyc;
        wait_grant(g, t);
        req_valid = 4'b0010;
        chk("midrst_grant", 32'(g), 32'd0);
        chk("midrst_grant_cycle", 32'(t), 32'(t_rel));
        wait_grant(g, t);
        req_valid = '0;
        chk("midrst_second", 32'(g), 32'd1);
        wait_idle();

        // Latency for SETTLE_CYCLES = 1 and 5.
        sw_valid = 4'b0001;
        #2;
        chk("sweep_grant", 32'({s1_ready, s5_ready}), 32'h11);
        lat1 = -1;
        lat5 = -1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            sw_valid = '0;
            #2;
            if (s1_rsp[0] && lat1 < 0) lat1 = n;
            if (s5_rsp[0] && lat5 < 0) lat5 = n;
        end
        chk("sweep_lat1", 32'(lat1), 32'd2);
        chk("sweep_lat5", 32'(lat5), 32'd6);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
